// File: rtl/seg7_multi_loader.sv
// seg7_multi_loader: latches a 4-bit switch value into one of NUM_DIGITS
// seven-segment digits using debounced active-low buttons. It supports a
// direct mode (one button per digit) and a sequential mode (an
// auto-advancing, blinking cursor).
module seg7_multi_loader #(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned BLINK_CYCLES    = 62500000
) (
    input  logic                    CLOCK_125_p,
    input  logic                    RST,
    input  logic [NUM_DIGITS-1:0]   KEY,
    input  logic [3:0]              SW,
    input  logic                    MODE,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic [2:0]              CURSOR,
    output logic [NUM_DIGITS-1:0]   LOADED
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned BLINK_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [6:0]  SEG_BLANK = 7'h7F;

    // key path state
    logic [NUM_DIGITS-1:0] key_meta;
    logic [NUM_DIGITS-1:0] key_sync;
    logic [NUM_DIGITS-1:0] key_stable;
    logic [DB_W-1:0]       db_cnt [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] press;

    // digit storage and control state
    logic [NUM_DIGITS-1:0][3:0] digit_val_q, digit_val_d;
    logic [NUM_DIGITS-1:0]      loaded_q, loaded_d;
    logic [2:0]                 cursor_q, cursor_d;
    logic                       mode_q;

    // blink timing
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_hidden;

    // Hex digit to active-low gfedcba segment pattern
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Synchronise, debounce and edge-detect each key; press is a one-cycle pulse on accepted 1->0
    always_ff @(posedge CLOCK_125_p) begin
        if (RST) begin
            key_meta   <= '1;
            key_sync   <= '1;
            key_stable <= '1;
            press      <= '0;
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            key_meta <= KEY;
            key_sync <= key_meta;
            press    <= '0;
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (key_sync[i] == key_stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    key_stable[i] <= key_sync[i];
                    db_cnt[i]     <= '0;
                    press[i]      <= ~key_sync[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Free-running blink counter; phase flips at each wrap
    always_ff @(posedge CLOCK_125_p) begin
        if (RST) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt    <= '0;
            blink_hidden <= ~blink_hidden;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    // Next digit/cursor state from press pulses and the sampled mode
    always_comb begin
        digit_val_d = digit_val_q;
        loaded_d    = loaded_q;
        cursor_d    = cursor_q;
        if (!mode_q) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (press[i]) begin
                    digit_val_d[i] = SW;
                    loaded_d[i]    = 1'b1;
                end
            end
        end else if (press[1]) begin
            // clear has priority over a simultaneous load
            digit_val_d = '0;
            loaded_d    = '0;
            cursor_d    = '0;
        end else if (press[0]) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (cursor_q == 3'(i)) begin
                    digit_val_d[i] = SW;
                    loaded_d[i]    = 1'b1;
                end
            end
            cursor_d = (cursor_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : cursor_q + 3'd1;
        end
    end

    // Digit, cursor and mode registers
    always_ff @(posedge CLOCK_125_p) begin
        if (RST) begin
            digit_val_q <= '0;
            loaded_q    <= '0;
            cursor_q    <= '0;
            mode_q      <= 1'b0;
        end else begin
            digit_val_q <= digit_val_d;
            loaded_q    <= loaded_d;
            cursor_q    <= cursor_d;
            mode_q      <= MODE;
        end
    end

    // Segment outputs decoded from registered state only
    always_comb begin
        HEX = '1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (!loaded_q[i] || (mode_q && blink_hidden && (cursor_q == 3'(i)))) begin
                HEX[7*i +: 7] = SEG_BLANK;
            end else begin
                HEX[7*i +: 7] = seg_decode(digit_val_q[i]);
            end
        end
    end

    assign CURSOR = cursor_q;
    assign LOADED = loaded_q;

endmodule
